uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the clock cycles per serial bit; legal range is 2 or more.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of buffered bytes; it is a power of 2 and at least 2.
REQ-003 Parameter DEBUG_UART, default 0, enables $display tracing of pops and bit shifts when set to 1; it has no effect on RTL behaviour.
REQ-004 Port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_tx_data, input, 8 bits: byte to transmit.
REQ-007 Port i_tx_dv, input, 1 bit: write strobe, sampled each cycle.
REQ-008 Port o_tx_ready, output, 1 bit: high when the FIFO is not full.
REQ-009 Port o_tx_serial, output, 1 bit: registered serial line; idle level is high.
REQ-010 Port o_tx_active, output, 1 bit: high while a frame (start, data or stop bit) is on the line.
REQ-011 Port o_tx_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 Port o_fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles, giving 10*CLKS_PER_BIT cycles per frame.
REQ-014 A write is accepted when i_tx_dv=1 and count<FIFO_DEPTH at that edge; a write while full is dropped with no state change, even if a pop occurs in the same cycle.
REQ-015 Simultaneous accepted push and pop keep count unchanged and preserve FIFO order.
REQ-016 The state machine uses states IDLE, START, DATA, STOP; the bit counter is 16 bits and the data-bit index is 3 bits.
REQ-017 In IDLE with a non-empty FIFO, the block pops one byte into the shift register, clears the bit counter, and moves to START; in IDLE with an empty FIFO it holds o_tx_serial=1.
REQ-018 With an empty FIFO and idle line, o_tx_serial falls on the 2nd rising edge after the edge that accepted the write.
REQ-019 START, DATA and STOP each advance when clk_count reaches CLKS_PER_BIT-1; DATA advances 8 times, with index 0 through 7, before moving to STOP.
REQ-020 At the end of STOP with a non-empty FIFO, the block pops and moves straight to START, so the next start bit immediately follows the stop bit with zero idle cycles.
REQ-021 At the end of STOP with an empty FIFO, the block moves to IDLE.
REQ-022 o_tx_done is high for exactly one cycle: the first cycle after the final stop-bit cycle.
REQ-023 o_tx_active is 0 in IDLE and 1 otherwise.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 While rst=1 at a clock edge, the following are loaded: state IDLE, o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_fifo_count=0, o_tx_ready=1, all counters 0, FIFO pointers 0.
REQ-026 Reset asserted mid-frame aborts the frame, returns the line high on the next cycle, flushes the FIFO, and generates no o_tx_done pulse.

Structure
REQ-027 The uart_pkg package holds the uart_state_t enum (IDLE/START/DATA/STOP) and localparams UART_DATA_BITS=8 and UART_STOP_BITS=1; the existing receiver is to migrate to it.
REQ-028 The FIFO is a separate sub-module, uart_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count); the FSM and shift logic stay in uart_tx_fifo.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: write 0xA5 at cycle 0, then observe the following.
- o_tx_serial is 0 for cycles 2-5.
- Data bits 1,0,1,0,0,1,0,1 follow, 4 cycles each, over cycles 6-37.
- Stop bit is 1 over cycles 38-41.
- o_tx_done=1 at cycle 42 only.
REQ-030 Overflow: write 6 bytes 0x01..0x06 on consecutive cycles.
- o_tx_ready drops once count reaches 4.
- 0x06 is dropped.
- 0x01..0x05 are transmitted in order.
REQ-031 Back-to-back: with 2 bytes queued, the second start bit begins on the cycle after the first stop bit ends, and o_tx_serial shows no extra high cycle.
REQ-032 Loopback: connect o_tx_serial to the receiver and send 0x00, 0xFF, 0x55 and 0x80; the receiver reports the same 4 bytes in order, each with a single-cycle o_rx_dv.
REQ-033 Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued; the next cycle shows o_tx_serial=1 and o_fifo_count=0, and no o_tx_done or further frame follows until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and frame constants.
// Used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-2 depth lets the pointers wrap on their own.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO.
// Back-to-back frames leave no idle gap on the line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEBUG_UART   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_tx_data,
  input  logic                        i_tx_dv,
  output logic                        o_tx_ready,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam logic [15:0] BitMax  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] StopMax =
    16'(CLKS_PER_BIT * UART_STOP_BITS - 1);
  localparam logic [2:0]  LastIdx = 3'(UART_DATA_BITS - 1);

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        serial_q, serial_d;
  logic        active_q;
  logic        evt_q, evt_d;
  logic        done_q;

  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  rdata;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_tx_dv),
    .wdata (i_tx_data),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (o_fifo_count)
  );

  if (DEBUG_UART != 0) begin : g_dbg
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = 1'b1;
    evt_d    = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = rdata;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        serial_d = data_q[idx_q];
        if (cnt_q == BitMax) begin
          cnt_d = '0;
          if (idx_q == LastIdx) state_d = STOP;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == StopMax) begin
          cnt_d = '0;
          evt_d = 1'b1;
          // Chain straight into the next start bit.
          if (!empty) begin
            pop     = 1'b1;
            data_d  = rdata;
            idx_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line, active and done lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      evt_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= (state_q != IDLE);
      evt_q    <= evt_d;
      done_q   <= evt_q;
    end
  end

  assign o_tx_ready  = ~full;
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

endmodule
